// File: rtl/leaf_seq_pkg.sv
// Shared types, defaults and helpers for the leaf round-robin sequencer.
//   - seq_state_e   : FSM state encoding (IDLE, GRANT, RELEASE)
//   - DEF_*         : default parameter values for the sequencer and picker
//   - idx_to_onehot : binary index to one-hot vector (up to MAX_REQ bits)
package leaf_seq_pkg;

    localparam int unsigned DEF_NUM_REQ  = 15;
    localparam int unsigned DEF_IDX_W    = 4;
    localparam int unsigned DEF_MAX_HOLD = 16;
    localparam int unsigned DEF_HOLD_W   = 5;

    // Upper bound on requesters; callers truncate the one-hot to their width.
    localparam int unsigned MAX_REQ      = 16;
    localparam int unsigned MAX_IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } seq_state_e;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i,
// wrapping from NUM_REQ-1 back to 0.
//   req_i     : request vector
//   start_i   : round-robin start index
//   win_idx_o : index of the winning request (0 when none)
//   found_o   : at least one request is set
module rr_pick
    import leaf_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = DEF_IDX_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               found_o
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Split into the region at/above start and the wrapped region below it;
    // scanning downward leaves the lowest index of each region.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                if (IDX_W'(j) >= start_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(j);
                end
            end
        end
        found_o   = hi_found | lo_found;
        win_idx_o = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/leaf_rr_sequencer.sv
// Round-robin sequencer sharing one execution slot among the leaf instances.
// A grant is held until done, request drop, or hold timeout; every grant is
// followed by one dead RELEASE cycle.
//   clk, rst      : clock, synchronous active-high reset
//   req, done     : per-leaf request (level) and completion
//   gnt           : registered one-hot grant
//   gnt_valid     : any grant bit high
//   gnt_idx       : binary index of granted leaf (0 when none)
//   timeout_pulse : one-cycle pulse on forced release
//   busy          : FSM in GRANT or RELEASE
module leaf_rr_sequencer
    import leaf_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned IDX_W    = DEF_IDX_W,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
    parameter int unsigned HOLD_W   = DEF_HOLD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               timeout_pulse,
    output logic               busy
);

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               done_sel;
    logic               req_sel;
    logic               hold_last;

    // cur_idx_q survives into RELEASE so the pointer can advance past it.
    always_comb begin
        ptr_next = ptr_q;
        if (state_q == RELEASE) begin
            ptr_next = (cur_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx_q + IDX_W'(1);
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i     (req),
        .start_i   (ptr_next),
        .win_idx_o (win_idx),
        .found_o   (win_found)
    );

    assign done_sel  = done[cur_idx_q];
    assign req_sel   = req[cur_idx_q];
    assign hold_last = (hold_q == HOLD_W'(MAX_HOLD - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   if (done_sel || !req_sel || hold_last) state_d = RELEASE;
            RELEASE: state_d = win_found ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        ptr_d       = ptr_q;
        cur_idx_d   = cur_idx_q;
        hold_d      = '0;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
        timeout_d   = 1'b0;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE, RELEASE: begin
                if (state_q == RELEASE) ptr_d = ptr_next;
                if (win_found) begin
                    cur_idx_d   = win_idx;
                    gnt_d       = NUM_REQ'(idx_to_onehot(MAX_IDX_W'(win_idx)));
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = win_idx;
                end
            end
            GRANT: begin
                if (state_d == GRANT) begin
                    hold_d      = hold_q + HOLD_W'(1);
                    gnt_d       = gnt_q;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = cur_idx_q;
                end else begin
                    // Only a pure timeout exit is reported.
                    timeout_d = !done_sel && req_sel;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cur_idx_q   <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cur_idx_q   <= cur_idx_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt           = gnt_q;
    assign gnt_valid     = gnt_valid_q;
    assign gnt_idx       = gnt_idx_q;
    assign timeout_pulse = timeout_q;
    assign busy          = busy_q;

endmodule

// File: doc/leaf_rr_sequencer.md
Name: leaf_rr_sequencer

Overview:
- Round-robin sequencer that shares one execution slot between the 15 leaf instances (inst_0..inst_14) of a generated hierarchy node.
- Leaves raise a request. Exactly one leaf at a time holds a one-hot grant until it signals done, drops its request, or hits a hold timeout.
- Sits in the hierarchy node alongside the 15 leaf instances and drives their enable/grant inputs.

Parameters:
- NUM_REQ, 15, number of leaf requesters (legal 2..16).
- IDX_W, 4, width of the grant index; must satisfy 2**IDX_W >= NUM_REQ.
- MAX_HOLD, 16, maximum number of GRANT-state cycles per grant before forced release (legal 2..2**HOLD_W).
- HOLD_W, 5, width of the hold counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-leaf request; level, held until served.
- done  input  NUM_REQ  per-leaf completion; only the bit of the granted leaf is sampled.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_valid  output  1  high while any gnt bit is high.
- gnt_idx  output  IDX_W  binary index of the granted leaf; 0 when gnt_valid is low.
- timeout_pulse  output  1  one-cycle pulse when a grant is force-released.
- busy  output  1  high when the FSM is in GRANT or RELEASE.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; gnt=0, gnt_valid=0, gnt_idx=0, timeout_pulse=0, busy=0; ptr=0; hold_cnt=0. Reset mid-grant drops the grant on that edge with no timeout pulse.
- ptr is the round-robin start index. The winner is the first set req bit at index ptr, ptr+1, ... with wrap NUM_REQ-1 -> 0.
- IDLE:
  - If any req bit is set, go to GRANT: set gnt one-hot at the winner, gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Latency: req high in cycle N (FSM in IDLE) gives gnt high in cycle N+1.
  - If req is all zero, stay in IDLE.
- GRANT: hold_cnt increments by 1 each cycle. Exit to RELEASE on the first of these, checked in this priority order:
  - (a) done[gnt_idx]=1;
  - (b) req[gnt_idx]=0 (requester abandoned);
  - (c) hold_cnt==MAX_HOLD-1 with neither (a) nor (b). Only this case asserts timeout_pulse, in the first RELEASE cycle.
  - If (a) or (b) coincide with the timeout cycle, there is no timeout pulse.
- Bits of done and req for non-granted leaves are ignored during GRANT. New requests arriving during GRANT are queued implicitly because req is level.
- RELEASE (exactly one cycle):
  - gnt=0, gnt_valid=0, gnt_idx=0.
  - ptr <= (granted index+1) mod NUM_REQ. Wrap: index NUM_REQ-1 gives ptr 0.
  - Arbitration is re-run in the same cycle using the updated pointer value (ptr_next, combinational). If any req bit is set, go to GRANT next edge; else go to IDLE.
  - Back-to-back: done sampled in cycle M gives gnt low in cycle M+1 and the next gnt high in cycle M+2. Consecutive grants are therefore always separated by at least one dead cycle.
- Fairness: with all 15 req bits held high, grants cycle 0,1,...,14,0 with no leaf repeating before all others have been served.
- busy=1 in GRANT and RELEASE, 0 in IDLE.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid equals OR of gnt.
  - hold_cnt never exceeds MAX_HOLD-1.

Decomposition:
- Shared package leaf_seq_pkg holds:
  - the state enum {IDLE, GRANT, RELEASE};
  - the NUM_REQ and IDX_W defaults;
  - the function idx_to_onehot.
- One combinational sub-module, rr_pick (inputs: req vector and start pointer; outputs: winner index and found flag). It is instantiated once and fed ptr_next.
- The FSM, hold counter and pointer live in leaf_rr_sequencer.

Test Plan:
1. Reset, then req=15'h0001 at cycle 1 -> gnt=0x0001, gnt_idx=0 at cycle 2; done[0] at cycle 5 -> gnt=0 at cycle 6, busy=0 at cycle 7.
2. All 15 req held high, each grantee asserts done one cycle after its grant -> gnt_idx sequence 0,1,...,14,0,1 with exactly one dead cycle between grants.
3. req=bit 3 only, done never asserted, MAX_HOLD=16 -> gnt high for exactly 16 cycles, timeout_pulse for one cycle on the first low cycle, ptr=4 afterwards.
4. Granted leaf 14 drops req while bits 0 and 7 request -> release without timeout, next grant goes to 0 (wrap), then 7.
5. rst asserted during GRANT of leaf 5 -> next edge gnt=0, timeout_pulse=0, ptr=0; with req bits 5 and 2 set after reset, leaf 2 is granted first.
6. done bit asserted for a non-granted leaf (done[9] while leaf 4 is granted) -> no release, hold_cnt keeps counting.
